// File: rtl/clk_period_meter_if.sv
// Measurement-side signals of the period meter: the sampled slow clock in, strobes and status out.
// master is the meter itself; slave is whoever drives sig_in and consumes the results.
interface clk_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  modport master (
    input  sig_in,
    output rise_pulse, fall_pulse, period, period_valid, locked, timeout
  );

  modport slave (
    output sig_in,
    input  rise_pulse, fall_pulse, period, period_valid, locked, timeout
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures the rise-to-rise period of an asynchronous slow clock in clk_in cycles and flags lock/loss.
// Strobes arrive SYNC_STAGES+1 cycles after the input edge; period/valid/lock update on that same edge; no backpressure.
module clk_period_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic                clk_in,
  input  logic                rst_n,
  clk_period_meter_if.master  mif
);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_t;

  localparam int               MW      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TOL     = CNT_W'(LOCK_TOL);
  localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [MW-1:0]          match_q, match_d;
  logic                   pv_q, pv_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;
  state_t                 state_q, state_d;

  logic                   sync_s;
  logic                   rise_det;
  logic                   fall_det;
  logic [CNT_W-1:0]       new_period;
  logic [CNT_W-1:0]       diff;
  logic                   in_tol;
  logic [MW-1:0]          match_inc;

  assign sync_s     = sync_q[SYNC_STAGES-1];
  assign rise_det   = sync_s & ~edge_q;
  assign fall_det   = ~sync_s & edge_q;
  assign new_period = cnt_q + CNT_W'(1);
  assign diff       = (new_period > period_q) ? (new_period - period_q) : (period_q - new_period);
  assign in_tol     = (diff <= TOL);
  assign match_inc  = match_q + MW'(1);

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], mif.sig_in};
    edge_d    = sync_s;
    rise_d    = rise_det;
    fall_d    = fall_det;
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
    period_d  = period_q;
    match_d   = match_q;
    pv_d      = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    state_d   = state_q;

    if (rise_det) begin
      cnt_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (rise_det) begin
          state_d   = ARMED;
          timeout_d = 1'b0;
          match_d   = '0;
        end
      end
      ARMED: begin
        // First interval has nothing to compare against, so it only seeds period.
        if (rise_det) begin
          period_d = new_period;
          pv_d     = 1'b1;
          match_d  = '0;
          state_d  = TRACK;
        end
      end
      TRACK: begin
        if (rise_det) begin
          period_d = new_period;
          pv_d     = 1'b1;
          if (in_tol) begin
            match_d = match_inc;
            if (match_inc == LOCK_N) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
      end
      LOCKED: begin
        if (rise_det) begin
          period_d = new_period;
          pv_d     = 1'b1;
          if (!in_tol) begin
            state_d  = TRACK;
            match_d  = '0;
            locked_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A rise on the saturating cycle still counts as a valid edge, so it beats the timeout.
    if ((state_q != IDLE) && !rise_det && (cnt_q == CNT_MAX)) begin
      state_d   = IDLE;
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      match_d   = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      edge_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      match_q   <= '0;
      pv_q      <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= sync_d;
      edge_q    <= edge_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      match_q   <= match_d;
      pv_q      <= pv_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      state_q   <= state_d;
    end
  end

  assign mif.rise_pulse   = rise_q;
  assign mif.fall_pulse   = fall_q;
  assign mif.period       = period_q;
  assign mif.period_valid = pv_q;
  assign mif.locked       = locked_q;
  assign mif.timeout      = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: two instances (LOCK_TOL 1 and 0) share one sig_in and are
// checked every cycle against an interval-based model, plus directed literal checks.
module tb_clk_period_meter;
  localparam int S    = 2;
  localparam int CW   = 16;
  localparam int LC   = 4;
  localparam int TO   = 60;
  localparam int MAXC = 4096;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic sig    = 1'b0;
  always #5 clk_in = ~clk_in;

  clk_period_meter_if #(.CNT_W(CW)) ifa ();
  clk_period_meter_if #(.CNT_W(CW)) ifb ();
  assign ifa.sig_in = sig;
  assign ifb.sig_in = sig;

  clk_period_meter #(.SYNC_STAGES(S), .CNT_W(CW), .LOCK_TOL(1), .LOCK_COUNT(LC), .TIMEOUT(TO)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .mif(ifa.master));
  clk_period_meter #(.SYNC_STAGES(S), .CNT_W(CW), .LOCK_TOL(0), .LOCK_COUNT(LC), .TIMEOUT(TO)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .mif(ifb.master));

  logic          o_rise [2];
  logic          o_fall [2];
  logic          o_pv   [2];
  logic          o_lock [2];
  logic          o_to   [2];
  logic [CW-1:0] o_per  [2];
  assign o_rise[0] = ifa.rise_pulse;   assign o_rise[1] = ifb.rise_pulse;
  assign o_fall[0] = ifa.fall_pulse;   assign o_fall[1] = ifb.fall_pulse;
  assign o_pv[0]   = ifa.period_valid; assign o_pv[1]   = ifb.period_valid;
  assign o_lock[0] = ifa.locked;       assign o_lock[1] = ifb.locked;
  assign o_to[0]   = ifa.timeout;      assign o_to[1]   = ifb.timeout;
  assign o_per[0]  = ifa.period;       assign o_per[1]  = ifb.period;

  int cyc = 0;
  int rst_mark = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Sample history of sig and rst_n, one entry per clk_in rising edge.
  logic samp [0:MAXC-1];
  logic rsmp [0:MAXC-1];
  always @(posedge clk_in) begin
    if (cyc < MAXC - 1) begin
      samp[cyc+1] <= sig;
      rsmp[cyc+1] <= rst_n;
    end
    cyc <= cyc + 1;
  end

  // Model: a rise is seen S cycles after it is sampled; period is the cycle distance between seen rises.
  int m_tol [2] = '{1, 0};
  bit m_armed [2], m_havep [2], m_pv [2], m_lock [2], m_to [2];
  int m_last [2], m_streak [2], m_per [2];
  bit m_rise, m_fall;

  function automatic bit samp_at(input int k);
    if (k <= rst_mark || k >= MAXC) return 1'b0;
    return (samp[k] === 1'b1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_armed[i] = 0; m_havep[i] = 0; m_pv[i] = 0; m_lock[i] = 0; m_to[i] = 0;
      m_last[i] = 0; m_streak[i] = 0; m_per[i] = 0;
    end
    m_rise = 0;
    m_fall = 0;
  endtask

  task automatic model_step();
    int p;
    int d;
    m_rise = samp_at(cyc - S) && !samp_at(cyc - S - 1);
    m_fall = !samp_at(cyc - S) && samp_at(cyc - S - 1);
    for (int i = 0; i < 2; i++) begin
      m_pv[i] = 0;
      if (m_rise) begin
        if (!m_armed[i]) begin
          m_armed[i] = 1; m_havep[i] = 0; m_to[i] = 0;
        end else begin
          p = cyc - m_last[i];
          if (!m_havep[i]) begin
            m_havep[i] = 1; m_streak[i] = 0;
          end else begin
            d = (p > m_per[i]) ? p - m_per[i] : m_per[i] - p;
            m_streak[i] = (d <= m_tol[i]) ? m_streak[i] + 1 : 0;
          end
          m_per[i]  = p;
          m_pv[i]   = 1;
          m_lock[i] = (m_streak[i] >= LC);
        end
        m_last[i] = cyc;
      end else if (m_armed[i] && (cyc - m_last[i] >= TO)) begin
        m_armed[i] = 0; m_havep[i] = 0; m_to[i] = 1; m_lock[i] = 0; m_streak[i] = 0;
      end
    end
  endtask

  // Directed-check bookkeeping on instance A (and lock activity on B).
  int pv_tot = 0, rise_cnt = 0, fall_cnt = 0, rise_at = 0, fall_at = 0;
  int last_rise_cyc = 0, to_delay = -1, b_lock_cyc = 0;
  logic lk_hist [0:255];
  int   per_hist [0:255];
  logic to_prev = 1'b0;

  always @(negedge clk_in) begin
    if (cyc == 0 || rsmp[cyc] !== 1'b1) begin
      rst_mark = cyc;
      model_reset();
    end else begin
      model_step();
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rise_pulse[%0d]", i),   int'(o_rise[i]), rst_n ? int'(m_rise) : 0);
      check($sformatf("fall_pulse[%0d]", i),   int'(o_fall[i]), rst_n ? int'(m_fall) : 0);
      check($sformatf("period[%0d]", i),       int'(o_per[i]),  rst_n ? m_per[i] : 0);
      check($sformatf("period_valid[%0d]", i), int'(o_pv[i]),   rst_n ? int'(m_pv[i]) : 0);
      check($sformatf("locked[%0d]", i),       int'(o_lock[i]), rst_n ? int'(m_lock[i]) : 0);
      check($sformatf("timeout[%0d]", i),      int'(o_to[i]),   rst_n ? int'(m_to[i]) : 0);
    end
    if (ifa.period_valid === 1'b1) begin
      if (pv_tot < 256) begin
        lk_hist[pv_tot]  = ifa.locked;
        per_hist[pv_tot] = int'(ifa.period);
      end
      pv_tot++;
    end
    if (ifa.rise_pulse === 1'b1) begin
      rise_cnt++; rise_at = cyc; last_rise_cyc = cyc;
    end
    if (ifa.fall_pulse === 1'b1) begin
      fall_cnt++; fall_at = cyc;
    end
    if (ifa.timeout === 1'b1 && to_prev !== 1'b1) to_delay = cyc - last_rise_cyc;
    if (ifb.locked === 1'b1) b_lock_cyc++;
    to_prev = ifa.timeout;
  end

  task automatic wave(input int hi, input int lo);
    sig = 1'b1;
    repeat (hi) @(negedge clk_in);
    sig = 1'b0;
    repeat (lo) @(negedge clk_in);
  endtask

  function automatic int hist_lk(input int k);
    if (k < 0 || k > 255) return -1;
    return int'(lk_hist[k]);
  endfunction

  function automatic int hist_per(input int k);
    if (k < 0 || k > 255) return -1;
    return per_hist[k];
  endfunction

  int base, b0, r0, f0, t0;

  initial begin
    repeat (3) @(negedge clk_in);
    #1;
    check("reset period", int'(ifa.period), 0);
    check("reset locked", int'(ifa.locked), 0);
    check("reset timeout", int'(ifa.timeout), 0);
    check("reset period_valid", int'(ifa.period_valid), 0);
    check("reset rise_pulse", int'(ifa.rise_pulse), 0);
    rst_n = 1'b1;

    // Steady period 4.
    base = pv_tot;
    wave(2, 2);
    #1;
    check("t1 first rise gives no valid", pv_tot - base, 0);
    repeat (6) wave(2, 2);
    #1;
    check("t1 valid count", pv_tot - base, 6);
    check("t1 not locked at 4th valid", hist_lk(base + 3), 0);
    check("t1 locked at 5th valid", hist_lk(base + 4), 1);
    check("t1 period", hist_per(base + 4), 4);

    // Switch to period 10.
    base = pv_tot;
    repeat (7) wave(5, 5);
    #1;
    check("t2 valid count", pv_tot - base, 7);
    check("t2 last 4-period", hist_per(base), 4);
    check("t2 first 10 period", hist_per(base + 1), 10);
    check("t2 unlock with first 10", hist_lk(base + 1), 0);
    check("t2 not locked at 4th 10", hist_lk(base + 4), 0);
    check("t2 locked at 5th 10", hist_lk(base + 5), 1);

    // Relock at 4, then hold high until timeout.
    repeat (7) wave(2, 2);
    sig = 1'b1;
    repeat (TO + 10) @(negedge clk_in);
    #1;
    check("t3 timeout delay", to_delay, TO);
    check("t3 timeout level", int'(ifa.timeout), 1);
    check("t3 locked dropped", int'(ifa.locked), 0);
    check("t3 period held", int'(ifa.period), 4);
    sig = 1'b0;
    repeat (3) @(negedge clk_in);
    base = pv_tot;
    sig = 1'b1;
    repeat (6) @(negedge clk_in);
    #1;
    check("t3 timeout cleared by rise", int'(ifa.timeout), 0);
    check("t3 no valid on rearm", pv_tot - base, 0);

    // Alternating 4/5: tolerance 1 locks, tolerance 0 never does.
    base = pv_tot;
    b0 = b_lock_cyc;
    sig = 1'b0;
    repeat (2) @(negedge clk_in);
    for (int k = 0; k < 6; k++) begin
      wave(2, 2);
      wave(2, 3);
    end
    #1;
    check("t4 valid count", pv_tot - base, 12);
    check("t4 not locked at 5th valid", hist_lk(base + 4), 0);
    check("t4 locked at 6th valid", hist_lk(base + 5), 1);
    check("t4 period at lock", hist_per(base + 5), 4);
    check("t4 tol1 locked", int'(ifa.locked), 1);
    check("t4 tol0 lock cycles", b_lock_cyc - b0, 0);

    // Asynchronous reset mid-tracking.
    repeat (3) wave(2, 2);
    sig = 1'b1;
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("t5 locked in reset", int'(ifa.locked), 0);
    check("t5 period in reset", int'(ifa.period), 0);
    check("t5 timeout in reset", int'(ifa.timeout), 0);
    check("t5 valid in reset", int'(ifa.period_valid), 0);
    check("t5 rise in reset", int'(ifa.rise_pulse), 0);
    check("t5 b period in reset", int'(ifb.period), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    base = pv_tot;
    r0 = rise_cnt;
    repeat (6) @(negedge clk_in);
    #1;
    check("t5 rise after release", rise_cnt - r0, 1);
    check("t5 no valid after release", pv_tot - base, 0);
    sig = 1'b0;
    repeat (2) @(negedge clk_in);
    repeat (2) wave(2, 2);
    #1;
    check("t5 valid count after rearm", pv_tot - base, 2);
    check("t5 period after rearm", hist_per(base + 1), 4);

    // Single-cycle pulse latency.
    repeat (20) @(negedge clk_in);
    #1;
    r0 = rise_cnt;
    f0 = fall_cnt;
    t0 = cyc;
    sig = 1'b1;
    @(negedge clk_in);
    sig = 1'b0;
    repeat (10) @(negedge clk_in);
    #1;
    check("t6 rise count", rise_cnt - r0, 1);
    check("t6 fall count", fall_cnt - f0, 1);
    check("t6 rise latency", rise_at - t0, S + 1);
    check("t6 fall latency", fall_at - (t0 + 1), S + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
